bcd_counter_multi_code: RTL and testbench



---
 rtl/bcd_counter_multi_code_pkg.sv | 13 +
 rtl/bcd_digit_code_conv.sv | 44 ++++
 rtl/bcd_counter_multi_code.sv | 108 ++++++++++
 tb/tb_bcd_counter_multi_code.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_multi_code_pkg.sv
// Shared constants and types for the multi-digit BCD counter.
// Code select encodings, digit limit and the digit type.
package bcd_counter_multi_code_pkg;

  localparam logic [1:0] CODE_8421 = 2'b00;
  localparam logic [1:0] CODE_2421 = 2'b01;
  localparam logic [1:0] CODE_XS3  = 2'b10;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [3:0] digit_t;

endpackage

// File: rtl/bcd_digit_code_conv.sv
// Combinational converter: one BCD digit to 8421, 2421 or excess-3.
// Digits above 9 map to 0000 whatever the selected code.
module bcd_digit_code_conv
  import bcd_counter_multi_code_pkg::*;
(
  input  digit_t     i_digit,
  input  logic [1:0] i_sel,
  output digit_t     o_code
);

  digit_t w_2421;
  logic   w_ok;

  assign w_ok = (i_digit <= BCD_MAX);

  always_comb begin
    w_2421 = 4'b0000;
    case (i_digit)
      4'd0:    w_2421 = 4'b0000;
      4'd1:    w_2421 = 4'b0001;
      4'd2:    w_2421 = 4'b0010;
      4'd3:    w_2421 = 4'b0011;
      4'd4:    w_2421 = 4'b0100;
      4'd5:    w_2421 = 4'b1011;
      4'd6:    w_2421 = 4'b1100;
      4'd7:    w_2421 = 4'b1101;
      4'd8:    w_2421 = 4'b1110;
      4'd9:    w_2421 = 4'b1111;
      default: w_2421 = 4'b0000;
    endcase
  end

  always_comb begin
    o_code = 4'b0000;
    if (w_ok) begin
      case (i_sel)
        CODE_2421: o_code = w_2421;
        CODE_XS3:  o_code = i_digit + 4'd3;
        default:   o_code = i_digit;
      endcase
    end
  end

endmodule

// File: rtl/bcd_counter_multi_code.sv
// Cascaded DIGITS-wide BCD up/down counter with sanitising load
// and per-digit run-time selectable output code.
module bcd_counter_multi_code
  import bcd_counter_multi_code_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up_dn,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic [1:0]          code_sel,
  output logic [4*DIGITS-1:0] count,
  output logic [4*DIGITS-1:0] code_out,
  output logic                carry,
  output logic                wrap,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] r_count;
  logic         r_wrap;
  logic         r_err;

  logic [W-1:0] w_next;
  logic [W-1:0] w_san;
  logic         w_roll;
  logic         w_bad;
  logic         w_all9;
  logic         w_all0;

  // Ripple: carry/borrow propagates while each digit rolls over.
  always_comb begin
    w_next = r_count;
    w_roll = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_roll) begin
        if (up_dn) begin
          if (r_count[4*i +: 4] == BCD_MAX) begin
            w_next[4*i +: 4] = 4'd0;
          end else begin
            w_next[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
            w_roll = 1'b0;
          end
        end else begin
          if (r_count[4*i +: 4] == 4'd0) begin
            w_next[4*i +: 4] = BCD_MAX;
          end else begin
            w_next[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
            w_roll = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    w_san  = '0;
    w_bad  = 1'b0;
    w_all9 = 1'b1;
    w_all0 = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > BCD_MAX) begin
        w_bad = 1'b1;
      end else begin
        w_san[4*i +: 4] = load_val[4*i +: 4];
      end
      if (r_count[4*i +: 4] != BCD_MAX) w_all9 = 1'b0;
      if (r_count[4*i +: 4] != 4'd0)    w_all0 = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else if (load) begin
      r_count <= w_san;
      r_wrap  <= 1'b0;
      r_err   <= w_bad;
    end else if (en) begin
      r_count <= w_next;
      r_wrap  <= w_roll;
      r_err   <= 1'b0;
    end else begin
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_conv
    bcd_digit_code_conv u_conv (
      .i_digit (r_count[4*g +: 4]),
      .i_sel   (code_sel),
      .o_code  (code_out[4*g +: 4])
    );
  end

  assign count    = r_count;
  assign wrap     = r_wrap;
  assign load_err = r_err;
  assign carry    = en & ~load & (up_dn ? w_all9 : w_all0);

endmodule

// File: tb/tb_bcd_counter_multi_code.sv
// Directed table-driven bench for bcd_counter_multi_code, DIGITS = 4.
// Hand sequences cover asynchronous reset corner cases.
module tb_bcd_counter_multi_code;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up_dn;
  logic        load;
  logic [15:0] load_val;
  logic [1:0]  code_sel;
  logic [15:0] count;
  logic [15:0] code_out;
  logic        carry;
  logic        wrap;
  logic        load_err;

  int n_pass;
  int n_total;

  typedef struct {
    logic        ld;
    logic [15:0] lv;
    logic        en;
    logic        ud;
    logic [1:0]  sel;
    logic [15:0] e_cnt;
    logic [15:0] e_code;
    logic        e_cy;
    logic        e_wr;
    logic        e_er;
  } vec_t;

  vec_t vq[$];

  bcd_counter_multi_code #(.DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .code_sel (code_sel),
    .count    (count),
    .code_out (code_out),
    .carry    (carry),
    .wrap     (wrap),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [15:0] lv,
                       input logic e, input logic ud,
                       input logic [1:0] sel);
    load     = ld;
    load_val = lv;
    en       = e;
    up_dn    = ud;
    code_sel = sel;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 2'b00);

    // ld lv en ud sel | count code carry wrap err
    vq.push_back('{1, 16'h9998, 1, 1, 2'd0, 16'h9998, 16'h9998, 0, 0, 0});
    vq.push_back('{0, 16'h0000, 1, 1, 2'd1, 16'h9999, 16'hFFFF, 1, 0, 0});
    vq.push_back('{0, 16'h0000, 1, 1, 2'd2, 16'h0000, 16'h3333, 0, 1, 0});
    vq.push_back('{0, 16'h0000, 0, 1, 2'd0, 16'h0000, 16'h0000, 0, 0, 0});
    vq.push_back('{1, 16'h0199, 0, 1, 2'd0, 16'h0199, 16'h0199, 0, 0, 0});
    vq.push_back('{0, 16'h0000, 1, 1, 2'd0, 16'h0200, 16'h0200, 0, 0, 0});
    vq.push_back('{1, 16'h0001, 1, 0, 2'd0, 16'h0001, 16'h0001, 0, 0, 0});
    vq.push_back('{0, 16'h0000, 1, 0, 2'd0, 16'h0000, 16'h0000, 1, 0, 0});
    vq.push_back('{0, 16'h0000, 1, 0, 2'd0, 16'h9999, 16'h9999, 0, 1, 0});
    vq.push_back('{1, 16'h0100, 0, 0, 2'd0, 16'h0100, 16'h0100, 0, 0, 0});
    vq.push_back('{0, 16'h0000, 1, 0, 2'd0, 16'h0099, 16'h0099, 0, 0, 0});
    vq.push_back('{1, 16'h7A3F, 1, 1, 2'd0, 16'h7030, 16'h7030, 0, 0, 1});
    vq.push_back('{0, 16'h0000, 0, 1, 2'd0, 16'h7030, 16'h7030, 0, 0, 0});
    vq.push_back('{1, 16'h5905, 0, 1, 2'd0, 16'h5905, 16'h5905, 0, 0, 0});
    vq.push_back('{0, 16'h0000, 0, 1, 2'd1, 16'h5905, 16'hBF0B, 0, 0, 0});
    vq.push_back('{0, 16'h0000, 0, 1, 2'd2, 16'h5905, 16'h8C38, 0, 0, 0});
    vq.push_back('{0, 16'h0000, 0, 1, 2'd3, 16'h5905, 16'h5905, 0, 0, 0});
    vq.push_back('{1, 16'h0042, 0, 1, 2'd0, 16'h0042, 16'h0042, 0, 0, 0});
    for (int k = 0; k < 5; k++)
      vq.push_back('{0, 16'h0000, 0, 1, 2'd0,
                     16'h0042, 16'h0042, 0, 0, 0});

    #2;
    chk("rst_count", count, 16'h0000);
    chk("rst_wrap", {15'd0, wrap}, 16'd0);
    chk("rst_err", {15'd0, load_err}, 16'd0);
    step();
    rst = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].ld, vq[i].lv, vq[i].en, vq[i].ud, vq[i].sel);
      step();
      chk($sformatf("v%0d_count", i), count, vq[i].e_cnt);
      chk($sformatf("v%0d_code", i), code_out, vq[i].e_code);
      chk($sformatf("v%0d_carry", i), {15'd0, carry}, {15'd0, vq[i].e_cy});
      chk($sformatf("v%0d_wrap", i), {15'd0, wrap}, {15'd0, vq[i].e_wr});
      chk($sformatf("v%0d_err", i), {15'd0, load_err}, {15'd0, vq[i].e_er});
    end

    // Asynchronous reset between edges, then release and count.
    drive(1'b1, 16'h0456, 1'b0, 1'b1, 2'b00);
    step();
    chk("pre_rst_count", count, 16'h0456);
    drive(1'b0, 16'h0000, 1'b1, 1'b1, 2'b00);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_count", count, 16'h0000);
    chk("async_rst_wrap", {15'd0, wrap}, 16'd0);
    chk("async_rst_err", {15'd0, load_err}, 16'd0);
    #1;
    rst = 1'b1;
    step();
    chk("rel_count", count, 16'h0001);

    // Reset in a wrap cycle clears wrap immediately.
    drive(1'b1, 16'h9999, 1'b0, 1'b1, 2'b00);
    step();
    drive(1'b0, 16'h0000, 1'b1, 1'b1, 2'b00);
    step();
    chk("wrap_pre_rst", {15'd0, wrap}, 16'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("wrap_rst_wrap", {15'd0, wrap}, 16'd0);
    chk("wrap_rst_count", count, 16'h0000);

    // Reset in a load-error cycle clears load_err immediately.
    rst = 1'b1;
    drive(1'b1, 16'hF000, 1'b0, 1'b1, 2'b00);
    step();
    chk("err_pre_rst", {15'd0, load_err}, 16'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("err_rst_err", {15'd0, load_err}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
